// File: rtl/cjg_clkmon_pkg.sv
// cjg_clkmon_pkg: shared state encoding and default parameters for the two-phase clock monitor.
package cjg_clkmon_pkg;
   typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;
   localparam int DEF_PERIOD     = 4;
   localparam int DEF_P2_OFFSET  = 2;
   localparam int DEF_LOCK_COUNT = 4;
   localparam int DEF_ERR_CNT_W  = 8;
endpackage

// File: rtl/cjg_sat_counter.sv
// cjg_sat_counter: saturating up-counter; increment wins over clear.
module cjg_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] count_o
);
   logic [W-1:0] count_q, count_d;
   always_comb count_d = inc_i ? ((&count_q) ? count_q : count_q + W'(1)) : clr_i ? '0 : count_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) count_q <= '0;
      else        count_q <= count_d;
   assign count_o = count_q;
endmodule

// File: rtl/cjg_clkmon.sv
// cjg_clkmon: locks to p1/p2 phase pulse trains, recovers phase, flags overlap/sequence faults.
// Optional CJG_CLKMON_STICKY_EN adds err_clr/err_sticky and clearable err_count.
module cjg_clkmon
   import cjg_clkmon_pkg::*;
#(
   parameter int PERIOD     = DEF_PERIOD,
   parameter int P2_OFFSET  = DEF_P2_OFFSET,
   parameter int LOCK_COUNT = DEF_LOCK_COUNT,
   parameter int ERR_CNT_W  = DEF_ERR_CNT_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      p1_in,
   input  logic                      p2_in,
`ifdef CJG_CLKMON_STICKY_EN
   input  logic                      err_clr,
   output logic                      err_sticky,
`endif
   output logic                      locked,
   output logic [$clog2(PERIOD)-1:0] phase,
   output logic                      err_overlap,
   output logic                      err_seq,
   output logic [ERR_CNT_W-1:0]      err_count
);
   localparam int PW = $clog2(PERIOD);
   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);
   localparam logic [PW-1:0] P2   = PW'(P2_OFFSET);
   state_t        state_q, state_d;
   logic [PW-1:0] pos_q, pos_d;
   logic [GW-1:0] good_q, good_d;
   logic          r_p1_q, r_p2_q, ov_q, ov_d, seq_q, seq_d, cnt_clr;
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      good_d  = good_q;
      ov_d    = 1'b0;
      seq_d   = 1'b0;
      if (state_q == SEARCH) begin
         if (r_p1_q && r_p2_q) ov_d = 1'b1;
         else if (r_p1_q) begin
            state_d = TRACK;
            pos_d   = PW'(1);
            good_d  = '0;
         end
      end else if (r_p1_q == (pos_q == '0) && r_p2_q == (pos_q == P2)) begin
         pos_d = (pos_q == LAST) ? '0 : pos_q + PW'(1);
         if (pos_q == LAST) begin
            good_d = (good_q == GW'(LOCK_COUNT)) ? good_q : good_q + GW'(1);
            if (state_q == TRACK && good_q == GW'(LOCK_COUNT - 1)) state_d = LOCKED;
         end
      end else begin
         // the faulting sample is dropped; the next clean p1 restarts tracking
         ov_d    = r_p1_q & r_p2_q;
         seq_d   = ~(r_p1_q & r_p2_q);
         state_d = SEARCH;
         pos_d   = '0;
         good_d  = '0;
      end
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_p1_q  <= 1'b0;
         r_p2_q  <= 1'b0;
         state_q <= SEARCH;
         pos_q   <= '0;
         good_q  <= '0;
         ov_q    <= 1'b0;
         seq_q   <= 1'b0;
      end else begin
         r_p1_q  <= p1_in;
         r_p2_q  <= p2_in;
         state_q <= state_d;
         pos_q   <= pos_d;
         good_q  <= good_d;
         ov_q    <= ov_d;
         seq_q   <= seq_d;
      end
`ifdef CJG_CLKMON_STICKY_EN
   logic sticky_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) sticky_q <= 1'b0;
      else        sticky_q <= ov_d | seq_d | (sticky_q & ~err_clr);
   assign err_sticky = sticky_q;
   assign cnt_clr    = err_clr;
`else
   assign cnt_clr = 1'b0;
`endif
   cjg_sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (ov_d | seq_d),
      .clr_i   (cnt_clr),
      .count_o (err_count)
   );
   assign locked      = (state_q == LOCKED);
   assign phase       = locked ? pos_q : '0;
   assign err_overlap = ov_q;
   assign err_seq     = seq_q;
endmodule

// File: tb/tb_cjg_clkmon.sv
// tb_cjg_clkmon: directed self-checking bench; outputs for input k are observed after step k+1.
module tb_cjg_clkmon;
   logic       clk = 1'b0, reset = 1'b0, p1_in = 1'b0, p2_in = 1'b0;
   logic       locked, err_overlap, err_seq;
   logic [1:0] phase;
   logic [7:0] err_count;
   int         checks = 0, errors = 0;
`ifdef CJG_CLKMON_STICKY_EN
   logic err_clr = 1'b0, err_sticky;
`endif
   cjg_clkmon dut (
      .clk         (clk),
      .reset       (reset),
      .p1_in       (p1_in),
      .p2_in       (p2_in),
`ifdef CJG_CLKMON_STICKY_EN
      .err_clr     (err_clr),
      .err_sticky  (err_sticky),
`endif
      .locked      (locked),
      .phase       (phase),
      .err_overlap (err_overlap),
      .err_seq     (err_seq),
      .err_count   (err_count)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic step(input logic p1, input logic p2);
      p1_in = p1;
      p2_in = p2;
      @(posedge clk);
      #1;
   endtask
   task automatic period(input int n);
      for (int i = 0; i < n; i++) begin
         step(1, 0); step(0, 0); step(0, 1); step(0, 0);
      end
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_locked", locked, 0);
      chk("rst_phase", phase, 0);
      chk("rst_ovl", err_overlap, 0);
      chk("rst_seq", err_seq, 0);
      chk("rst_cnt", err_count, 0);
      reset = 1'b1;
      repeat (3) step(0, 0);
      chk("idle_seq", err_seq, 0);
      // ideal pattern: locks when the 4th period's last sample is processed
      period(4);
      chk("pre_lock", locked, 0);
      step(1, 0);
      chk("lock", locked, 1);
      chk("ph0", phase, 0);
      step(0, 0);
      chk("ph1", phase, 1);
      step(0, 1);
      chk("ph2", phase, 2);
      step(0, 0);
      chk("ph3", phase, 3);
      chk("cnt_ideal", err_count, 0);
      // overlap at position 0 while locked
      step(1, 1);
      chk("ph0b", phase, 0);
      step(0, 0);
      chk("ovl_pulse", err_overlap, 1);
      chk("ovl_noseq", err_seq, 0);
      chk("ovl_unlock", locked, 0);
      chk("ovl_cnt", err_count, 1);
      step(0, 1);
      chk("ovl_1cyc", err_overlap, 0);
      step(0, 0);
      period(4);
      chk("ovl_prelock", locked, 0);
      step(1, 0);
      chk("ovl_relock", locked, 1);
      // suppressed p2
      step(0, 0); step(0, 0); step(0, 0);
      chk("miss_seq", err_seq, 1);
      chk("miss_noovl", err_overlap, 0);
      chk("miss_unlock", locked, 0);
      chk("miss_cnt", err_count, 2);
      step(1, 0);
      chk("miss_1cyc", err_seq, 0);
      step(0, 0); step(0, 1); step(0, 0);
      period(3);
      step(1, 0);
      chk("miss_relock", locked, 1);
      // early p1 at position 3 is discarded, next p1 restarts tracking
      step(0, 0); step(0, 1); step(1, 0); step(1, 0);
      chk("early_seq", err_seq, 1);
      chk("early_cnt", err_count, 3);
      step(0, 0);
      chk("early_resync", err_seq, 0);
      step(0, 1); step(0, 0);
      period(3);
      chk("early_prelock", locked, 0);
      step(1, 0);
      chk("early_relock", locked, 1);
      // saturation
      repeat (300) step(1, 1);
      chk("sat_ovl", err_overlap, 1);
      chk("sat_cnt", err_count, 255);
      step(0, 0); step(0, 0);
      chk("sat_hold", err_count, 255);
      chk("sat_ovl_end", err_overlap, 0);
      // both low forever
      repeat (20) step(0, 0);
      chk("low_seq", err_seq, 0);
      chk("low_locked", locked, 0);
      chk("low_cnt", err_count, 255);
      // async reset mid-operation
      period(2);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_cnt", err_count, 0);
      chk("mid_rst_locked", locked, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      period(4);
      step(1, 0);
      chk("rst_relock", locked, 1);
      chk("rst_relock_cnt", err_count, 0);
`ifdef CJG_CLKMON_STICKY_EN
      step(1, 1); step(0, 0);
      chk("stk_set", err_sticky, 1);
      chk("stk_cnt1", err_count, 1);
      repeat (4) step(0, 0);
      chk("stk_hold", err_sticky, 1);
      err_clr = 1'b1;
      step(0, 0);
      err_clr = 1'b0;
      chk("stk_clr", err_sticky, 0);
      chk("stk_cnt_clr", err_count, 0);
      step(1, 1);
      err_clr = 1'b1;
      step(0, 0);
      err_clr = 1'b0;
      chk("stk_setwins", err_sticky, 1);
      chk("stk_incwins", err_count, 1);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
